// File: rtl/sram_bank_arbiter.sv
// Two-requester arbiter in front of four 32x512 SRAM macros.
// Requester A is a Wishbone slave port, requester B is a simple req/gnt port.
// All macro controls are registered; reads share one result register.
//
// state  | meaning
// IDLE   | sample requests, grant one, load macro controls for the access
// ACCESS | exactly one chip-select low (write port or read port)
// WAIT   | read only: READ_LAT cycles until the macro output is sampled
// RESP   | one-cycle completion pulse to the owner, no request sampling
module sram_bank_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    input  logic         b_req_i,
    input  logic         b_we_i,
    input  logic [12:0]  b_addr_i,
    input  logic [3:0]   b_wmask_i,
    input  logic [31:0]  b_wdata_i,
    output logic         b_gnt_o,
    output logic         b_rvalid_o,
    output logic [31:0]  b_rdata_o,
    output logic [3:0]   sram_csb0_o,
    output logic         sram_web0_o,
    output logic [3:0]   sram_wmask0_o,
    output logic [8:0]   sram_addr0_o,
    output logic [31:0]  sram_din0_o,
    output logic [3:0]   sram_csb1_o,
    output logic [8:0]   sram_addr1_o,
    input  logic [127:0] sram_dout1_i,
    output logic         arb_busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(READ_LAT - 1);

    state_t      state_q;
    logic        prio_b_q;
    logic        owner_b_q;
    logic        we_q;
    logic [1:0]  bank_q;
    logic [1:0]  wait_cnt_q;
    logic [31:0] rdata_q;
    logic        ack_a_q;
    logic        rvalid_q;
    logic [3:0]  csb0_q;
    logic        web0_q;
    logic [3:0]  wmask0_q;
    logic [8:0]  addr0_q;
    logic [31:0] din0_q;
    logic [3:0]  csb1_q;
    logic [8:0]  addr1_q;

    logic        req_a;
    logic        grant_a_d;
    logic        grant_b_d;
    logic        we_d;
    logic [1:0]  bank_d;
    logic [8:0]  word_d;
    logic [3:0]  mask_d;
    logic [31:0] wdata_d;

    // Byte-lane and upper address bits carry no meaning for a 2 KiB-per-bank map.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wbs_adr_i[31:13], wbs_adr_i[1:0], b_addr_i[1:0]};

    // Round-robin grant decision and selection of the winner's access fields.
    always_comb begin
        req_a     = wbs_cyc_i & wbs_stb_i;
        grant_b_d = (state_q == S_IDLE) && b_req_i && (!req_a || prio_b_q);
        grant_a_d = (state_q == S_IDLE) && req_a && !grant_b_d;
        if (grant_b_d) begin
            we_d    = b_we_i;
            bank_d  = b_addr_i[12:11];
            word_d  = b_addr_i[10:2];
            mask_d  = b_wmask_i;
            wdata_d = b_wdata_i;
        end else begin
            we_d    = wbs_we_i;
            bank_d  = wbs_adr_i[12:11];
            word_d  = wbs_adr_i[10:2];
            mask_d  = wbs_sel_i;
            wdata_d = wbs_dat_i;
        end
    end

    // Arbiter FSM with registered macro controls and completion pulses.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            prio_b_q   <= 1'b0;
            owner_b_q  <= 1'b0;
            we_q       <= 1'b0;
            bank_q     <= 2'd0;
            wait_cnt_q <= 2'd0;
            rdata_q    <= 32'd0;
            ack_a_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            csb0_q     <= 4'hF;
            web0_q     <= 1'b1;
            wmask0_q   <= 4'd0;
            addr0_q    <= 9'd0;
            din0_q     <= 32'd0;
            csb1_q     <= 4'hF;
            addr1_q    <= 9'd0;
        end else begin
            ack_a_q  <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_a_d || grant_b_d) begin
                        state_q   <= S_ACCESS;
                        owner_b_q <= grant_b_d;
                        prio_b_q  <= grant_a_d;
                        we_q      <= we_d;
                        bank_q    <= bank_d;
                        if (we_d) begin
                            csb0_q   <= ~(4'b0001 << bank_d);
                            web0_q   <= 1'b0;
                            wmask0_q <= mask_d;
                            addr0_q  <= word_d;
                            din0_q   <= wdata_d;
                        end else begin
                            csb1_q  <= ~(4'b0001 << bank_d);
                            addr1_q <= word_d;
                        end
                    end
                end
                S_ACCESS: begin
                    csb0_q   <= 4'hF;
                    web0_q   <= 1'b1;
                    wmask0_q <= 4'd0;
                    addr0_q  <= 9'd0;
                    din0_q   <= 32'd0;
                    csb1_q   <= 4'hF;
                    addr1_q  <= 9'd0;
                    if (we_q) begin
                        state_q  <= S_RESP;
                        ack_a_q  <= !owner_b_q;
                        rvalid_q <= owner_b_q;
                    end else begin
                        state_q    <= S_WAIT;
                        wait_cnt_q <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        state_q  <= S_RESP;
                        rdata_q  <= sram_dout1_i[{bank_q, 5'b00000} +: 32];
                        ack_a_q  <= !owner_b_q;
                        rvalid_q <= owner_b_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A master that let go of cyc/stb before completion gets no ack.
    assign wbs_ack_o     = ack_a_q & wbs_cyc_i & wbs_stb_i;
    assign wbs_dat_o     = rdata_q;
    assign b_rdata_o     = rdata_q;
    assign b_rvalid_o    = rvalid_q;
    assign b_gnt_o       = grant_b_d;
    assign arb_busy_o    = (state_q != S_IDLE);
    assign sram_csb0_o   = csb0_q;
    assign sram_web0_o   = web0_q;
    assign sram_wmask0_o = wmask0_q;
    assign sram_addr0_o  = addr0_q;
    assign sram_din0_o   = din0_q;
    assign sram_csb1_o   = csb1_q;
    assign sram_addr1_o  = addr1_q;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a behavioural four-bank SRAM model.
module tb_sram_bank_arbiter;

    localparam int RL = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]   wbs_sel_i = 4'd0;
    logic [31:0]  wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic         b_req_i = 1'b0, b_we_i = 1'b0;
    logic [12:0]  b_addr_i = 13'd0;
    logic [3:0]   b_wmask_i = 4'd0;
    logic [31:0]  b_wdata_i = 32'd0;
    logic         b_gnt_o, b_rvalid_o;
    logic [31:0]  b_rdata_o;
    logic [3:0]   sram_csb0_o, sram_wmask0_o, sram_csb1_o;
    logic         sram_web0_o;
    logic [8:0]   sram_addr0_o, sram_addr1_o;
    logic [31:0]  sram_din0_o;
    logic [127:0] sram_dout1_i;
    logic         arb_busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_bank_arbiter #(.READ_LAT(RL)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i),
        .b_wmask_i(b_wmask_i), .b_wdata_i(b_wdata_i),
        .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
        .sram_csb0_o(sram_csb0_o), .sram_web0_o(sram_web0_o),
        .sram_wmask0_o(sram_wmask0_o), .sram_addr0_o(sram_addr0_o),
        .sram_din0_o(sram_din0_o), .sram_csb1_o(sram_csb1_o),
        .sram_addr1_o(sram_addr1_o), .sram_dout1_i(sram_dout1_i),
        .arb_busy_o(arb_busy_o)
    );

    // Four macros: masked write on port 0, read captured on port 1.
    logic [31:0] mem [4][512];
    logic [31:0] dout_q [4];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (m[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (!sram_csb0_o[n] && !sram_web0_o)
                mem[n][sram_addr0_o] <= merge(mem[n][sram_addr0_o], sram_din0_o, sram_wmask0_o);
            if (!sram_csb1_o[n])
                dout_q[n] <= mem[n][sram_addr1_o];
        end
    end
    assign sram_dout1_i = {dout_q[3], dout_q[2], dout_q[1], dout_q[0]};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          is_b;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [3:0]  exp_csb;
        logic [8:0]  exp_word;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    // One complete transaction starting in an IDLE cycle, just after a rising edge.
    task automatic do_txn(input vec_t v);
        if (v.is_b) begin
            b_req_i = 1'b1; b_we_i = v.we; b_addr_i = v.addr[12:0];
            b_wmask_i = v.mask; b_wdata_i = v.wdata;
        end else begin
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
            wbs_adr_i = v.addr; wbs_sel_i = v.mask; wbs_dat_i = v.wdata;
        end
        @(negedge clk);
        check("grant_gnt", 32'(b_gnt_o), 32'(v.is_b));
        check("grant_busy", 32'(arb_busy_o), 32'd0);
        @(posedge clk); #1;
        b_req_i = 1'b0;
        b_addr_i = ~b_addr_i; b_wmask_i = ~b_wmask_i; b_wdata_i = ~b_wdata_i;
        wbs_adr_i = ~wbs_adr_i; wbs_sel_i = ~wbs_sel_i; wbs_dat_i = ~wbs_dat_i;
        @(negedge clk);
        check("access_busy", 32'(arb_busy_o), 32'd1);
        if (v.we) begin
            check("w_csb0", 32'(sram_csb0_o), 32'(v.exp_csb));
            check("w_csb1", 32'(sram_csb1_o), 32'hF);
            check("w_web0", 32'(sram_web0_o), 32'd0);
            check("w_addr0", 32'(sram_addr0_o), 32'(v.exp_word));
            check("w_wmask0", 32'(sram_wmask0_o), 32'(v.mask));
            check("w_din0", sram_din0_o, v.wdata);
        end else begin
            check("r_csb1", 32'(sram_csb1_o), 32'(v.exp_csb));
            check("r_csb0", 32'(sram_csb0_o), 32'hF);
            check("r_addr1", 32'(sram_addr1_o), 32'(v.exp_word));
            repeat (RL) begin
                @(negedge clk);
                check("wait_csb", 32'({sram_csb0_o, sram_csb1_o}), 32'hFF);
            end
        end
        @(negedge clk);
        check("resp_csb", 32'({sram_csb0_o, sram_csb1_o}), 32'hFF);
        check("resp_ack", 32'(wbs_ack_o), 32'(!v.is_b));
        check("resp_rvalid", 32'(b_rvalid_o), 32'(v.is_b));
        if (!v.we)
            check("resp_rdata", v.is_b ? b_rdata_o : wbs_dat_o, v.exp_rdata);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        check("post_busy", 32'(arb_busy_o), 32'd0);
        check("post_pulses", 32'({wbs_ack_o, b_rvalid_o}), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int pulses;
        //         is_b we  addr           wdata          mask     csb      word    rdata
        vecs[0] = '{1'b0, 1'b1, 32'h0000_1804, 32'hDEAD_BEEF, 4'b1111, 4'b0111, 9'h001, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_1804, 32'h0,         4'b1111, 4'b0111, 9'h001, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0808, 32'hAABB_CCDD, 4'b1111, 4'b1101, 9'h002, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0808, 32'h1122_3344, 4'b0011, 4'b1101, 9'h002, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0808, 32'h0,         4'b0000, 4'b1101, 9'h002, 32'hAABB_3344};
        vecs[5] = '{1'b0, 1'b1, 32'hFFFF_E7FC, 32'h0123_4567, 4'b1111, 4'b1110, 9'h1FF, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_07FC, 32'hCAFE_F00D, 4'b1100, 4'b1110, 9'h1FF, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_07FF, 32'h0,         4'b0000, 4'b1110, 9'h1FF, 32'hCAFE_4567};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_1806, 32'h0,         4'b0000, 4'b0111, 9'h001, 32'hDEAD_BEEF};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_csb0", 32'(sram_csb0_o), 32'hF);
        check("rst_csb1", 32'(sram_csb1_o), 32'hF);
        check("rst_web0", 32'(sram_web0_o), 32'd1);
        check("rst_addr0", 32'(sram_addr0_o), 32'd0);
        check("rst_din0", sram_din0_o, 32'd0);
        check("rst_pulses", 32'({wbs_ack_o, b_rvalid_o, b_gnt_o}), 32'd0);
        check("rst_rdata", wbs_dat_o, 32'd0);
        check("rst_busy", 32'(arb_busy_o), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) do_txn(vecs[i]);

        // Reset while an A write is in ACCESS.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h0000_0000; wbs_sel_i = 4'hF; wbs_dat_i = 32'h5555_5555;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstacc_csb0_before", 32'(sram_csb0_o), 32'hE);
        #1 rst = 1'b1;
        #1;
        check("rstacc_csb0", 32'(sram_csb0_o), 32'hF);
        check("rstacc_csb1", 32'(sram_csb1_o), 32'hF);
        check("rstacc_busy", 32'(arb_busy_o), 32'd0);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            pulses += int'(wbs_ack_o) + int'(b_rvalid_o) + int'(arb_busy_o);
        end
        check("rstacc_no_completion", 32'(pulses), 32'd0);
        @(posedge clk); #1;

        // Simultaneous A/B reads: A first after reset, then B, then A again.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0000_1804;
        b_req_i = 1'b1; b_we_i = 1'b0; b_addr_i = 13'h0808;
        @(negedge clk);
        check("pair_first_gnt", 32'(b_gnt_o), 32'd0);
        @(negedge clk);
        check("pair_a_csb1", 32'(sram_csb1_o), 32'h7);
        repeat (RL) @(negedge clk);
        @(negedge clk);
        check("pair_a_ack", 32'(wbs_ack_o), 32'd1);
        check("pair_a_dat", wbs_dat_o, 32'hDEAD_BEEF);
        @(negedge clk);
        check("pair_b_gnt", 32'(b_gnt_o), 32'd1);
        check("pair_b_idle", 32'(arb_busy_o), 32'd0);
        @(posedge clk); #1;
        b_req_i = 1'b0;
        @(negedge clk);
        check("pair_b_csb1", 32'(sram_csb1_o), 32'hD);
        repeat (RL) @(negedge clk);
        @(negedge clk);
        check("pair_b_rvalid", 32'(b_rvalid_o), 32'd1);
        check("pair_b_rdata", b_rdata_o, 32'hAABB_3344);
        check("pair_b_no_ack", 32'(wbs_ack_o), 32'd0);
        @(negedge clk);
        check("pair_a2_gnt", 32'(b_gnt_o), 32'd0);
        @(negedge clk);
        check("pair_a2_csb1", 32'(sram_csb1_o), 32'h7);
        repeat (RL) @(negedge clk);
        @(negedge clk);
        check("pair_a2_ack", 32'(wbs_ack_o), 32'd1);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        check("pair_done_busy", 32'(arb_busy_o), 32'd0);
        @(posedge clk); #1;

        // A abandons a read during WAIT: access completes silently.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0000_0808;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        pulses = 0;
        repeat (RL) begin
            @(negedge clk);
            pulses += int'(wbs_ack_o);
        end
        @(negedge clk);
        pulses += int'(wbs_ack_o);
        check("drop_no_ack", 32'(pulses), 32'd0);
        check("drop_resp_busy", 32'(arb_busy_o), 32'd1);
        check("drop_rdata", wbs_dat_o, 32'hAABB_3344);
        @(negedge clk);
        check("drop_idle", 32'(arb_busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
